// File: rtl/vanilla_int_scoreboard.sv
// vanilla_int_scoreboard
//   Pending-writeback tracker for integer registers written by long-latency
//   operations (remote loads, idiv, AMO). It sits in ID right after the
//   decoder and raises dependency_o when the instruction in ID would read
//   (RAW) or overwrite (WAW) a register whose result is still outstanding.
//
// Ports
//   clk_i          core clock
//   reset_i        synchronous, active-high reset
//   src_id_i       packed source ids; slot i at [i*id_w +: id_w] (slot 0 = rs1)
//   op_reads_i     per-slot read qualifiers (bit 0 = read_rs1)
//   dest_id_i      rd of the instruction in ID
//   op_writes_i    write_rd qualifier
//   score_i        long-latency op issues: mark dest_id_i pending
//   clear_i        long-latency writeback this cycle
//   clear_id_i     register being written back
//   dependency_o   RAW/WAW hazard for the instruction in ID (combinational)
//   scoreboard_o   registered pending-bit vector
//   pending_cnt_o  registered number of pending bits
//   empty_o        no pending bits (fence/barrier drain)
module vanilla_int_scoreboard #(
  parameter int els_p     = 32,
  parameter int num_src_p = 2,
  parameter int x0_tied_p = 1,
  localparam int id_w     = $clog2(els_p),
  localparam int cnt_w    = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_src_p*id_w-1:0] src_id_i,
  input  logic [num_src_p-1:0]      op_reads_i,
  input  logic [id_w-1:0]           dest_id_i,
  input  logic                      op_writes_i,
  input  logic                      score_i,
  input  logic                      clear_i,
  input  logic [id_w-1:0]           clear_id_i,
  output logic                      dependency_o,
  output logic [els_p-1:0]          scoreboard_o,
  output logic [cnt_w-1:0]          pending_cnt_o,
  output logic                      empty_o
);

  localparam bit X0_TIED = (x0_tied_p != 0);

  logic [els_p-1:0] r_sb;
  logic [cnt_w-1:0] r_cnt;

  logic [els_p-1:0] w_sb_next;
  logic [els_p-1:0] w_clr_mask;
  logic [els_p-1:0] w_eff;
  logic [cnt_w-1:0] w_cnt_next;
  logic             w_score_eff;
  logic             w_clear_eff;
  logic             w_dep;

  // Scoring x0 is a no-op when it is hardwired to zero; a clear only counts
  // when it actually drops a pending bit.
  assign w_score_eff = score_i & ~(X0_TIED & (dest_id_i == '0));
  assign w_clear_eff = clear_i & r_sb[clear_id_i];

  always_comb begin
    // Clear is applied before score, so clear+score of one id leaves it set.
    w_sb_next = r_sb;
    if (clear_i)     w_sb_next[clear_id_i] = 1'b0;
    if (w_score_eff) w_sb_next[dest_id_i]  = 1'b1;

    w_cnt_next = r_cnt;
    if (w_score_eff && !w_clear_eff)      w_cnt_next = r_cnt + cnt_w'(1);
    else if (!w_score_eff && w_clear_eff) w_cnt_next = r_cnt - cnt_w'(1);
  end

  // Hazard view: a writeback landing this cycle already releases its
  // dependents (zero-bubble bypass). Only ids and score/clear feed state;
  // the read/write qualifiers only reach dependency_o.
  always_comb begin
    w_clr_mask = '0;
    if (clear_i) w_clr_mask[clear_id_i] = 1'b1;
    w_eff = r_sb & ~w_clr_mask;
    if (X0_TIED) w_eff[0] = 1'b0;

    w_dep = op_writes_i & w_eff[dest_id_i];
    for (int i = 0; i < num_src_p; i++) begin
      w_dep = w_dep | (op_reads_i[i] & w_eff[src_id_i[i*id_w +: id_w]]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sb  <= '0;
      r_cnt <= '0;
    end else begin
      r_sb  <= w_sb_next;
      r_cnt <= w_cnt_next;

      // Protocol checks: the pipeline guarantees none of these occur.
      assert (!(w_score_eff && r_sb[dest_id_i] && !(clear_i && (clear_id_i == dest_id_i))))
        else $error("scoreboard: score of already pending register %0d", dest_id_i);
      assert (!(clear_i && !r_sb[clear_id_i] && !(X0_TIED && (clear_id_i == '0))))
        else $error("scoreboard: clear of register %0d that is not pending", clear_id_i);
      assert (!(score_i && (w_dep === 1'b1)))
        else $error("scoreboard: score issued while dependency is raised");
    end
  end

  assign dependency_o  = w_dep;
  assign scoreboard_o  = r_sb;
  assign pending_cnt_o = r_cnt;
  assign empty_o       = (r_cnt == '0);

endmodule
